// File: rtl/ysyx_23060191_lsu.sv
// Load/store unit: one instruction in flight, valid/ready on both the pipeline and the data bus.
// Handles byte/half/word lanes, sign/zero extension and misalignment reporting.
module ysyx_23060191_lsu #(
    parameter int CPU_WIDTH     = 32,
    parameter int LSU_OPT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CPU_WIDTH-1:0]     exu_res,
    input  logic [CPU_WIDTH-1:0]     data_Rs2,
    input  logic [LSU_OPT_WIDTH-1:0] lsu_opt_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CPU_WIDTH-1:0]     lsu_res,
    output logic                     lsu_err,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_wen,
    output logic [CPU_WIDTH-1:0]     mem_req_addr,
    output logic [CPU_WIDTH-1:0]     mem_req_wdata,
    output logic [3:0]               mem_req_wmask,
    input  logic                     mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]     mem_rsp_rdata
);

    localparam logic [LSU_OPT_WIDTH-1:0] OP_LB  = LSU_OPT_WIDTH'(1);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_LH  = LSU_OPT_WIDTH'(2);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_LW  = LSU_OPT_WIDTH'(3);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_LBU = LSU_OPT_WIDTH'(4);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_LHU = LSU_OPT_WIDTH'(5);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_SB  = LSU_OPT_WIDTH'(6);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_SH  = LSU_OPT_WIDTH'(7);
    localparam logic [LSU_OPT_WIDTH-1:0] OP_SW  = LSU_OPT_WIDTH'(8);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                   state;
    logic [LSU_OPT_WIDTH-1:0] op_q;
    logic [1:0]               off_q;

    logic                     op_load, op_store, op_half, op_word;
    logic                     misalign;
    logic [1:0]               off;
    logic [3:0]               store_mask;
    logic [CPU_WIDTH-1:0]     rsp_word, load_data;

    assign in_ready = (state == S_IDLE);
    assign off      = exu_res[1:0];

    always_comb begin
        op_load  = 1'b0;
        op_store = 1'b0;
        op_half  = 1'b0;
        op_word  = 1'b0;
        case (lsu_opt_code)
            OP_LB, OP_LBU: op_load = 1'b1;
            OP_LH, OP_LHU: begin op_load = 1'b1; op_half = 1'b1; end
            OP_LW:         begin op_load = 1'b1; op_word = 1'b1; end
            OP_SB:         op_store = 1'b1;
            OP_SH:         begin op_store = 1'b1; op_half = 1'b1; end
            OP_SW:         begin op_store = 1'b1; op_word = 1'b1; end
            default:       ;
        endcase
    end

    assign misalign   = (op_half & off[0]) | (op_word & (off != 2'b00));
    assign store_mask = op_word ? 4'b1111 : (op_half ? (4'b0011 << off) : (4'b0001 << off));

    // Response is decoded with the opcode and lane offset captured at acceptance.
    always_comb begin
        rsp_word = mem_rsp_rdata >> {off_q, 3'b000};
        case (op_q)
            OP_LB:   load_data = {{(CPU_WIDTH-8){rsp_word[7]}}, rsp_word[7:0]};
            OP_LBU:  load_data = {{(CPU_WIDTH-8){1'b0}}, rsp_word[7:0]};
            OP_LH:   load_data = {{(CPU_WIDTH-16){rsp_word[15]}}, rsp_word[15:0]};
            OP_LHU:  load_data = {{(CPU_WIDTH-16){1'b0}}, rsp_word[15:0]};
            OP_LW:   load_data = rsp_word;
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= '0;
            off_q         <= '0;
            out_valid     <= 1'b0;
            lsu_res       <= '0;
            lsu_err       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q  <= lsu_opt_code;
                    off_q <= off;
                    if (!(op_load | op_store)) begin
                        lsu_res   <= exu_res;
                        lsu_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (misalign) begin
                        lsu_res   <= '0;
                        lsu_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_wen   <= op_store;
                        mem_req_addr  <= {exu_res[CPU_WIDTH-1:2], 2'b00};
                        mem_req_wdata <= data_Rs2 << {off, 3'b000};
                        mem_req_wmask <= op_store ? store_mask : 4'b0000;
                        state         <= S_REQ;
                    end
                end
                S_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: if (mem_rsp_valid) begin
                    lsu_res   <= mem_req_wen ? '0 : load_data;
                    lsu_err   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// Randomized and directed checks of the LSU against an arithmetic reference of the access rules.
// A scripted bus model drives ready/response with chosen delays.
module tb_ysyx_23060191_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] exu_res, data_Rs2;
    logic [3:0]  lsu_opt_code;
    logic        out_valid, out_ready;
    logic [31:0] lsu_res;
    logic        lsu_err;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060191_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exu_res(exu_res), .data_Rs2(data_Rs2), .lsu_opt_code(lsu_opt_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .lsu_res(lsu_res), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 pass-through, 1 misaligned, 2 load, 3 store
    task automatic model(input logic [3:0] op, input logic [31:0] addr, data, rdata,
                         output int kind, output logic [31:0] e_res, e_addr, e_wdata,
                         output logic [3:0] e_mask, output logic e_wen);
        int size, off;
        logic [31:0] v;
        size = (op == 1 || op == 4 || op == 6) ? 1 :
               (op == 2 || op == 5 || op == 7) ? 2 :
               (op == 3 || op == 8) ? 4 : 0;
        off     = int'(addr % 4);
        e_addr  = addr - off;
        e_wdata = data << (8 * off);
        e_mask  = 4'(((1 << size) - 1) << off);
        e_wen   = (op >= 6 && op <= 8);
        if (size == 0) begin
            kind = 0; e_res = addr;
        end else if (addr % size != 0) begin
            kind = 1; e_res = 0;
        end else if (e_wen) begin
            kind = 3; e_res = 0;
        end else begin
            kind = 2;
            v = rdata >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (op == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (op == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            e_res = v;
            e_mask = 4'b0000;
        end
    endtask

    // Garbage on the input side while busy must never be taken.
    task automatic scramble();
        in_valid     = 1'b1;
        exu_res      = $urandom;
        data_Rs2     = $urandom;
        lsu_opt_code = 4'($urandom_range(0, 15));
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, data, rdata,
                          input int req_wait, rsp_wait, out_wait);
        int kind;
        logic [31:0] e_res, e_addr, e_wdata;
        logic [3:0]  e_mask;
        logic        e_wen;
        model(op, addr, data, rdata, kind, e_res, e_addr, e_wdata, e_mask, e_wen);
        check_val("idle_in_ready", in_ready, 1);
        in_valid = 1'b1; lsu_opt_code = op; exu_res = addr; data_Rs2 = data;
        @(posedge clk); #1;
        scramble();
        if (kind < 2) begin
            check_val("fast_out_valid", out_valid, 1);
            check_val("fast_no_req", mem_req_valid, 0);
        end else begin
            for (int i = 0; i <= req_wait; i++) begin
                check_val("req_valid", mem_req_valid, 1);
                check_val("req_addr", mem_req_addr, e_addr);
                check_val("req_wen", mem_req_wen, e_wen);
                check_val("req_wmask", mem_req_wmask, e_mask);
                if (e_wen) check_val("req_wdata", mem_req_wdata, e_wdata);
                check_val("busy_in_ready", in_ready, 0);
                check_val("req_no_out", out_valid, 0);
                mem_req_ready = (i == req_wait);
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rsp_rdata = $urandom;
                @(posedge clk); #1;
                scramble();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            check_val("req_drop", mem_req_valid, 0);
            for (int i = 0; i < rsp_wait; i++) begin
                check_val("wait_no_out", out_valid, 0);
                @(posedge clk); #1;
                scramble();
            end
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
            scramble();
            check_val("mem_out_valid", out_valid, 1);
        end
        for (int i = 0; i <= out_wait; i++) begin
            check_val("out_valid_hold", out_valid, 1);
            check_val("lsu_res", lsu_res, e_res);
            check_val("lsu_err", lsu_err, (kind == 1));
            check_val("done_in_ready", in_ready, 0);
            if (i == out_wait) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (i != out_wait) scramble();
        end
        out_ready = 1'b0;
        check_val("retire_out_valid", out_valid, 0);
        check_val("retire_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; exu_res = '0; data_Rs2 = '0; lsu_opt_code = '0;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        #22;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_lsu_res", lsu_res, 0);
        check_val("rst_req_valid", mem_req_valid, 0);
        check_val("rst_req_addr", mem_req_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", in_ready, 1);

        do_txn(4'd0, 32'h12345678, 32'h0, 32'h0, 0, 0, 0);
        do_txn(4'd1, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0);
        do_txn(4'd4, 32'h80000003, 32'h0, 32'h80FF1234, 1, 2, 0);
        do_txn(4'd7, 32'h80000002, 32'h0000ABCD, $urandom, 3, 1, 0);
        do_txn(4'd3, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0, 2);
        do_txn(4'd3, 32'h80000002, 32'h0, 32'h0, 0, 0, 0);
        do_txn(4'd2, 32'h80000001, 32'h0, 32'h0, 0, 0, 0);
        do_txn(4'd12, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 0, 1);

        // retire and new input in the same cycle: one-bubble gap
        in_valid = 1'b1; lsu_opt_code = 4'd0; exu_res = 32'hCAFE0001;
        @(posedge clk); #1;
        check_val("bub_first_valid", out_valid, 1);
        out_ready = 1'b1; exu_res = 32'h0BADF00D;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bub_gap_valid", out_valid, 0);
        check_val("bub_gap_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("bub_second_valid", out_valid, 1);
        check_val("bub_second_res", lsu_res, 32'h0BADF00D);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset while waiting for the response, then a stale response
        in_valid = 1'b1; lsu_opt_code = 4'd3; exu_res = 32'h80000008;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_req_valid", mem_req_valid, 0);
        check_val("mid_rst_addr", mem_req_addr, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("stale_rsp_out_valid", out_valid, 0);
            check_val("stale_rsp_req_valid", mem_req_valid, 0);
            check_val("stale_rsp_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 80; n++) begin
            do_txn(4'($urandom_range(0, 15)), 32'h80000000 | 32'($urandom_range(0, 1023)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
